alu_wide_seq: RTL and testbench

//  Multi-word arithmetic sequencer that sits in front of the team's 16-bit combinational ALU.
//  It accepts one WORDS*16-bit operation over a valid/ready request channel. It drives the
//  ALU one 16-bit slice per cycle, least-significant slice first, and chains the ALU carry

---
 rtl/alu_wide_seq_pkg.sv | 30 +++
 rtl/alu_wide_seq.sv | 152 +++++++++++++++
 tb/tb_alu_wide_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_wide_seq_pkg.sv
// Shared constants for the multi-word ALU sequencer: slice width, ALU
// opcodes, request opcodes and the FSM state encoding.
package alu_wide_seq_pkg;

    // Slice width of the 16-bit combinational ALU.
    localparam int DW = 16;

    // Opcodes understood by the 16-bit ALU.
    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SUB = 2'b01;
    localparam logic [1:0] ALU_OP_NEG = 2'b10;
    localparam logic [1:0] ALU_OP_XOR = 2'b11;

    // Opcodes on the wide request channel.
    localparam logic [1:0] REQ_OP_ADD = 2'b00;
    localparam logic [1:0] REQ_OP_SUB = 2'b01;
    localparam logic [1:0] REQ_OP_NEG = 2'b10;
    localparam logic [1:0] REQ_OP_XOR = 2'b11;

    // Sequencer FSM encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Subtract and negate are built as a + ~b + 1, so they start with carry 1.
    function automatic logic init_carry(input logic [1:0] op);
        return (op == REQ_OP_SUB) || (op == REQ_OP_NEG);
    endfunction

endpackage

// File: rtl/alu_wide_seq.sv
// Multi-word arithmetic sequencer: feeds a 16-bit ALU one slice per cycle,
// least-significant slice first, chaining the carry between slices.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Valid, once raised, holds with its payload stable until the
// transfer; ready may change freely and never depends on valid.
module alu_wide_seq
    import alu_wide_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DW*WORDS-1:0]   req_a,
    input  logic [DW*WORDS-1:0]   req_b,
    output logic [DW-1:0]         alu_a,
    output logic [DW-1:0]         alu_b,
    output logic [1:0]            alu_opcode,
    output logic                  alu_ci,
    input  logic [DW-1:0]         alu_out,
    input  logic                  alu_carryout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DW*WORDS-1:0]   rsp_result,
    output logic                  rsp_carry,
    output logic [1:0]            dbg_state
);

    localparam int OW = DW * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    op_q, op_d;
    logic [OW-1:0] a_q, a_d;
    logic [OW-1:0] b_q, b_d;
    logic          carry_q, carry_d;
    logic [OW-1:0] result_q, result_d;

    logic [DW-1:0] a_slice;
    logic [DW-1:0] b_slice;

    // Current operand slices selected by the slice index.
    always_comb begin
        a_slice = a_q[idx_q*DW +: DW];
        b_slice = b_q[idx_q*DW +: DW];
    end

    // Next-state logic: capture on accept, one slice per RUN cycle, hold in DONE.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    idx_d   = '0;
                    carry_d = init_carry(req_op);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[idx_q*DW +: DW] = alu_out;
                carry_d = (op_q == REQ_OP_XOR) ? 1'b0 : alu_carryout;
                idx_d   = idx_q + IW'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            op_q     <= REQ_OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            result_q <= result_d;
        end
    end

    // ALU drive: sub and negate become add with inverted b; zero outside RUN.
    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = ALU_OP_ADD;
        alu_ci     = 1'b0;
        if (state_q == ST_RUN) begin
            case (op_q)
                REQ_OP_ADD: begin
                    alu_a  = a_slice;
                    alu_b  = b_slice;
                    alu_ci = carry_q;
                end
                REQ_OP_SUB: begin
                    alu_a  = a_slice;
                    alu_b  = ~b_slice;
                    alu_ci = carry_q;
                end
                REQ_OP_NEG: begin
                    alu_a  = '0;
                    alu_b  = ~b_slice;
                    alu_ci = carry_q;
                end
                default: begin
                    alu_opcode = ALU_OP_XOR;
                    alu_a      = a_slice;
                    alu_b      = b_slice;
                end
            endcase
        end
    end

    // Handshake and response outputs decoded from registered state.
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        rsp_valid  = (state_q == ST_DONE);
        rsp_result = result_q;
        rsp_carry  = carry_q;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Testbench for alu_wide_seq (WORDS=4) with a behavioural 16-bit ALU beside it.
module tb_alu_wide_seq;
    import alu_wide_seq_pkg::*;

    localparam int WORDS = 4;
    localparam int OW    = DW * WORDS;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [OW-1:0] req_a;
    logic [OW-1:0] req_b;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [1:0]    alu_opcode;
    logic          alu_ci;
    logic [DW-1:0] alu_out;
    logic          alu_carryout;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [OW-1:0] rsp_result;
    logic          rsp_carry;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [OW:0] exp_q[$];

    alu_wide_seq #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_ci(alu_ci),
        .alu_out(alu_out), .alu_carryout(alu_carryout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural 16-bit ALU ----------------
    always_comb begin
        alu_out      = '0;
        alu_carryout = 1'b0;
        case (alu_opcode)
            2'b00: {alu_carryout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_ci};
            2'b01: begin
                alu_out      = alu_a - alu_b;
                alu_carryout = (alu_a >= alu_b);
            end
            2'b10: begin
                alu_out      = -alu_b;
                alu_carryout = (alu_b == '0);
            end
            default: alu_out = alu_a ^ alu_b;
        endcase
    end

    task automatic chk(input string nm, input logic [OW:0] act, input logic [OW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got 0x%0h with no expected entry", {rsp_carry, rsp_result});
            end else begin
                chk("rsp", {rsp_carry, rsp_result}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    // Issues one operation, checks latency, per-RUN-cycle opcode and initial ci,
    // and optionally holds rsp_ready low in DONE for hold cycles.
    task automatic run_op(input logic [1:0] op, input logic [OW-1:0] a, input logic [OW-1:0] b,
                          input logic [OW-1:0] er, input logic ec, input int hold);
        int n;
        int w;
        logic [1:0] exp_opc;
        exp_opc = (op == REQ_OP_XOR) ? ALU_OP_XOR : ALU_OP_ADD;
        w = 0;
        while (!req_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
            return;
        end
        rsp_ready = (hold == 0);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back({ec, er});
        // Inputs change after acceptance; they must have no effect.
        req_valid = 1'b0;
        req_op = 2'($urandom_range(0, 3));
        req_a  = {$urandom, $urandom};
        req_b  = {$urandom, $urandom};
        chk("alu_ci_init", {64'd0, alu_ci}, {64'd0, init_carry(op)});
        n = 0;
        while (!rsp_valid && n < 20) begin
            chk("alu_opcode_run", {63'd0, alu_opcode}, {63'd0, exp_opc});
            @(posedge clk); #1; n++;
        end
        chk("latency", OW'(n), OW'(WORDS));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                chk("hold_result", {rsp_carry, rsp_result}, {ec, er});
                chk("hold_req_ready", {64'd0, req_ready}, '0);
                chk("hold_rsp_valid", {64'd0, rsp_valid}, {64'd0, 1'b1});
                @(posedge clk); #1;
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    // Checks every output against its reset value.
    task automatic chk_reset_vals(input string nm);
        chk({nm, "_state"},     {63'd0, dbg_state}, {63'd0, ST_IDLE});
        chk({nm, "_req_ready"}, {64'd0, req_ready}, {64'd0, 1'b1});
        chk({nm, "_rsp_valid"}, {64'd0, rsp_valid}, '0);
        chk({nm, "_rsp"},       {rsp_carry, rsp_result}, '0);
        chk({nm, "_alu"},       {30'd0, alu_a, alu_b, alu_opcode, alu_ci}, '0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        #12;
        chk_reset_vals("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(REQ_OP_ADD, 64'h0000_0000_0000_FFFF, 64'd1, 64'h0000_0000_0001_0000, 1'b0, 0);
        run_op(REQ_OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 0);
        run_op(REQ_OP_SUB, 64'h0001_0000_0000_0000, 64'd1, 64'h0000_FFFF_FFFF_FFFF, 1'b1, 0);
        run_op(REQ_OP_SUB, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        run_op(REQ_OP_NEG, 64'h1234_5678_9ABC_DEF0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        run_op(REQ_OP_NEG, 64'hFFFF_0000_FFFF_0000, 64'd0, 64'd0, 1'b1, 0);
        run_op(REQ_OP_XOR, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h5555_5555_5555_5555, 1'b0, 0);
        run_op(REQ_OP_ADD, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
               64'h2222_2222_2222_2211, 1'b0, 0);
        // Backpressure in DONE.
        run_op(REQ_OP_SUB, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0002,
               64'h0000_0000_FFFF_FFFE, 1'b1, 5);

        // Abort mid-RUN with an asynchronous reset pulse.
        req_op = REQ_OP_ADD; req_a = 64'hFFFF_FFFF_FFFF_FFFF; req_b = 64'd5; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Recovery after the abort.
        run_op(REQ_OP_XOR, 64'h0F0F_0F0F_0F0F_0F0F, 64'h00FF_00FF_00FF_00FF,
               64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", OW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
